// File: rtl/axi_sram_controller.sv
// axi_sram_controller: AXI4-Lite slave bridging to a single-port synchronous SRAM, writes win over reads
module axi_sram_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [31:0]                  wdata,
    input  logic [3:0]                   wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [31:0]                  araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [31:0]                  rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [3:0]                   mem_wen,
    output logic                         mem_ren,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);
    localparam int aw = $clog2(MEM_WORDS);
    localparam logic [32:0] lo = {1'b0, BASE_ADDR};
    localparam logic [32:0] hi = lo + 33'(4 * MEM_WORDS);

    typedef enum logic [2:0] {IDLE, WR, BRESP, RD, RDATA, RRESP} state_t;
    state_t state;

    logic        aw_held, w_held, wr_ok, rd_ok;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs, w_hs, go_wr;
    logic [31:0] wa, wd;
    logic [3:0]  ws;

    // 33-bit compare so the window top cannot wrap past 2^32
    function automatic logic in_rng(input logic [31:0] a);
        return {1'b0, a} >= lo && {1'b0, a} < hi;
    endfunction

    function automatic logic [aw-1:0] idx(input logic [31:0] a);
        return aw'((a - BASE_ADDR) >> 2);
    endfunction

    assign awready = state == IDLE && !aw_held;
    assign wready  = state == IDLE && !w_held;
    assign arready = state == IDLE && !aw_held && !w_held && !awvalid && !wvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign go_wr   = (aw_held || aw_hs) && (w_held || w_hs);
    assign wa      = aw_held ? awaddr_q : awaddr;
    assign wd      = w_held ? wdata_q : wdata;
    assign ws      = w_held ? wstrb_q : wstrb;

    // Transaction FSM; SRAM strobes are registered on entry to WR/RD so they last exactly one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            bvalid    <= 1'b0;
            rvalid    <= 1'b0;
            mem_wen   <= 4'b0;
            mem_ren   <= 1'b0;
            bresp     <= 2'b00;
            rresp     <= 2'b00;
            rdata     <= 32'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        awaddr_q <= awaddr;
                        aw_held  <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        w_held  <= 1'b1;
                    end
                    if (go_wr) begin
                        state     <= WR;
                        wr_ok     <= in_rng(wa);
                        mem_addr  <= in_rng(wa) ? idx(wa) : mem_addr;
                        mem_wdata <= wd;
                        mem_wen   <= in_rng(wa) ? ws : 4'b0;
                    end else if (arvalid && arready) begin
                        state    <= RD;
                        rd_ok    <= in_rng(araddr);
                        mem_ren  <= in_rng(araddr);
                        mem_addr <= in_rng(araddr) ? idx(araddr) : mem_addr;
                    end
                end
                WR: begin
                    mem_wen <= 4'b0;
                    bvalid  <= 1'b1;
                    bresp   <= wr_ok ? 2'b00 : 2'b10;
                    state   <= BRESP;
                end
                BRESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RD: begin
                    mem_ren <= 1'b0;
                    state   <= RDATA;
                end
                RDATA: begin
                    rdata  <= rd_ok ? mem_rdata : 32'b0;
                    rresp  <= rd_ok ? 2'b00 : 2'b10;
                    rvalid <= 1'b1;
                    state  <= RRESP;
                end
                RRESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_controller.sv
// tb_axi_sram_controller: directed and randomized AXI-Lite traffic checked against a word-array memory model
module tb_axi_sram_controller;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WORDS = 1024;

    logic        clk, rst, load;
    logic [31:0] awaddr, wdata, araddr, rdata, mem_wdata, mem_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, mem_ren;
    logic [3:0]  wstrb, mem_wen;
    logic [1:0]  bresp, rresp;
    logic [9:0]  mem_addr;

    int checks = 0, errors = 0;
    int wen_cnt = 0, ren_cnt = 0, b_cnt = 0;
    logic [31:0] ref_mem [WORDS];
    logic [31:0] sram [WORDS];
    logic [31:0] got;

    axi_sram_controller #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input int i);
        return 32'(i) * 32'h9E37_79B1 ^ 32'hA5A5_0F0F;
    endfunction

    // SRAM with byte enables plus pulse/handshake counters
    always @(posedge clk) begin
        if (load) for (int i = 0; i < WORDS; i++) sram[i] <= seed(i);
        else for (int i = 0; i < 4; i++) if (mem_wen[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        if (mem_ren) mem_rdata <= sram[mem_addr];
        if (mem_wen != 4'b0) wen_cnt <= wen_cnt + 1;
        if (mem_ren) ren_cnt <= ren_cnt + 1;
        if (bvalid && bready) b_cnt <= b_cnt + 1;
    end

    function automatic logic in_win(input logic [31:0] a);
        return 64'(a) >= 64'(BASE) && 64'(a) < 64'(BASE) + 64'(4 * WORDS);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic rdy(input int ch);
        return ch == 0 ? awready : ch == 1 ? wready : arready;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input int ch);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy(ch) && n < 50);
        chk($sformatf("ready_ch%0d", ch), 64'(rdy(ch)), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic rst_chk();
        @(negedge clk);
        chk("rst_ready", 64'({awready, wready, arready}), 64'b111);
        chk("rst_valid", 64'({bvalid, rvalid, mem_ren}), 64'd0);
        chk("rst_wen", 64'(mem_wen), 64'd0);
        chk("rst_resp", 64'({bresp, rresp}), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_maddr", 64'(mem_addr), 64'd0);
        chk("rst_mwdata", 64'(mem_wdata), 64'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int mode, input int stall);
        logic ok;
        int w0, b0, n;
        ok = in_win(a); w0 = wen_cnt; b0 = b_cnt; n = 0;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; bready = (stall == 0);
        if (mode == 0) begin
            awvalid = 1; wvalid = 1; wait_rdy(0);
        end else if (mode == 1) begin
            wvalid = 1; wait_rdy(1); wvalid = 0;
            @(negedge clk); chk("w_held", 64'({awready, wready}), 64'b10);
            @(posedge clk); #1; awvalid = 1; wait_rdy(0);
        end else begin
            awvalid = 1; wait_rdy(0); awvalid = 0;
            @(negedge clk); chk("aw_held", 64'({awready, wready}), 64'b01);
            @(posedge clk); #1; wvalid = 1; wait_rdy(1);
        end
        awvalid = 0; wvalid = 0;
        if (ok) for (int i = 0; i < 4; i++) if (s[i]) ref_mem[widx(a)][8*i +: 8] = d[8*i +: 8];
        do begin
            @(negedge clk); n++;
            if (n == 1) begin
                chk("wr_wen", 64'(mem_wen), 64'(ok ? s : 4'b0));
                if (ok) chk("wr_addr", 64'(mem_addr), 64'(widx(a)));
                if (ok) chk("wr_data", 64'(mem_wdata), 64'(d));
            end
        end while (!bvalid && n < 20);
        chk("b_latency", 64'(n), 64'd2);
        chk("bresp", 64'(bresp), 64'(ok ? 2'b00 : 2'b10));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("b_stall", 64'({bvalid, bresp, awready, arready}), 64'({1'b1, ok ? 2'b00 : 2'b10, 2'b00}));
        end
        bready = 1;
        @(posedge clk); #1;
        chk("wen_pulses", 64'(wen_cnt - w0), 64'((ok && s != 4'b0) ? 1 : 0));
        chk("b_count", 64'(b_cnt - b0), 64'd1);
    endtask

    task automatic rd_tail(input logic [31:0] a, input int stall, output logic [31:0] data);
        logic ok;
        logic [31:0] exp;
        int r0, n;
        ok = in_win(a); exp = ok ? ref_mem[widx(a)] : 32'b0; r0 = ren_cnt; n = 0;
        rready = (stall == 0);
        do begin
            @(negedge clk); n++;
            if (n == 1) begin
                chk("rd_ren", 64'(mem_ren), 64'(ok));
                if (ok) chk("rd_addr", 64'(mem_addr), 64'(widx(a)));
            end
        end while (!rvalid && n < 20);
        chk("r_latency", 64'(n), 64'd3);
        chk("rdata", 64'(rdata), 64'(exp));
        chk("rresp", 64'(rresp), 64'(ok ? 2'b00 : 2'b10));
        data = rdata;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("r_stall", 64'({rvalid, rresp, rdata, arready, awready}), 64'({1'b1, ok ? 2'b00 : 2'b10, exp, 2'b00}));
        end
        rready = 1;
        @(posedge clk); #1;
        chk("ren_pulses", 64'(ren_cnt - r0), 64'(ok ? 1 : 0));
    endtask

    task automatic rd(input logic [31:0] a, input int stall, output logic [31:0] data);
        @(posedge clk); #1;
        araddr = a; arvalid = 1;
        wait_rdy(2);
        arvalid = 0;
        rd_tail(a, stall, data);
    endtask

    function automatic logic [31:0] pick();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if (r < 8) return BASE + 32'($urandom_range(1008, 1023) * 4);
        return r == 8 ? 32'hFFFF_FFFC : 32'h0000_2000 + 32'($urandom_range(0, 64) * 4);
    endfunction

    initial begin
        int n, b0;
        rst = 1; load = 1;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = seed(i);
        repeat (2) @(posedge clk);
        #1; rst = 0; load = 0;
        rst_chk();

        wr(32'h0000_1000, 32'h5678_0000, 4'b1100, 0, 0);
        wr(32'h0000_1000, 32'hABCD_1234, 4'b0011, 0, 0);
        rd(32'h0000_1000, 0, got);
        chk("strobe_merge", 64'(got), 64'h5678_1234);

        wr(32'h0000_1004, 32'h1111_2222, 4'b1111, 1, 0);
        wr(32'h0000_1008, 32'h3333_4444, 4'b1111, 2, 0);
        wr(32'h0000_100C, 32'h5555_6666, 4'b1111, 0, 0);
        rd(32'h0000_1008, 0, got);

        wr(32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 0, 0);
        rd(32'h0000_0FFC, 0, got);
        rd(32'hFFFF_FFFC, 0, got);
        wr(32'h0000_1FFF, 32'hCAFE_F00D, 4'b1010, 0, 0);
        rd(32'h0000_1FFC, 0, got);
        wr(32'h0000_1010, 32'hFFFF_FFFF, 4'b0000, 0, 0);
        rd(32'h0000_1010, 0, got);

        @(posedge clk); #1;
        awaddr = 32'h0000_1020; wdata = 32'h0BAD_CAFE; wstrb = 4'b1111; araddr = 32'h0000_1020;
        awvalid = 1; wvalid = 1; arvalid = 1; b0 = b_cnt;
        wait_rdy(0);
        awvalid = 0; wvalid = 0;
        ref_mem[widx(32'h0000_1020)] = 32'h0BAD_CAFE;
        n = 0;
        do begin
            @(negedge clk); n++;
            chk("prio_ar_early", 64'(arready && b_cnt == b0), 64'd0);
        end while (!arready && n < 20);
        chk("prio_b_done", 64'(b_cnt - b0), 64'd1);
        @(posedge clk); #1;
        arvalid = 0;
        rd_tail(32'h0000_1020, 0, got);

        rd(32'h0000_1004, 10, got);
        wr(32'h0000_1030, 32'h7777_8888, 4'b0110, 0, 10);
        wr(32'h0000_3000, 32'h7777_8888, 4'b1111, 0, 10);

        @(posedge clk); #1;
        araddr = 32'h0000_1004; arvalid = 1;
        wait_rdy(2);
        arvalid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        rst_chk();
        rd(32'h0000_1004, 0, got);

        @(posedge clk); #1;
        awaddr = 32'h0000_1040; wdata = 32'h9999_AAAA; wstrb = 4'b1111; bready = 0;
        awvalid = 1; wvalid = 1;
        wait_rdy(0);
        awvalid = 0; wvalid = 0;
        ref_mem[widx(32'h0000_1040)] = 32'h9999_AAAA;
        repeat (2) @(negedge clk);
        chk("bresp_before_rst", 64'(bvalid), 64'd1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; bready = 1;
        rst_chk();
        rd(32'h0000_1040, 0, got);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 1) == 1) wr(pick(), $urandom, 4'($urandom), $urandom_range(0, 2), 0);
            else rd(pick(), 0, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_sram_controller.md
# axi_sram_controller

AXI4-Lite slave that bridges the system AXI bus to a single-port synchronous SRAM. It sits downstream of `axi_controller`, beside `axi_rom_controller` on the bus, and adds writable memory with per-byte write strobes. It serialises reads and writes onto the one SRAM port and gives writes priority. It returns SLVERR for addresses outside its window.

## Interface
- `BASE_ADDR`, 32'h0000_1000: byte address of SRAM word 0; must be 4-byte aligned.
- `MEM_WORDS`, 1024: SRAM depth in 32-bit words; power of two.
- `clk` in 1: system clock; all logic samples on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `awaddr` in 32, `awvalid` in 1, `awready` out 1: AXI write-address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: AXI write-data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: AXI write-response channel.
- `araddr` in 32, `arvalid` in 1, `arready` out 1: AXI read-address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: AXI read-data channel.
- `mem_addr` out $clog2(MEM_WORDS): SRAM word index.
- `mem_wen` out 4: per-byte SRAM write enables. Bit i writes `mem_wdata[8i+7:8i]`.
- `mem_ren` out 1: SRAM read enable.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data, valid in the cycle after `mem_ren`.

## Operation
- States: IDLE, WR, BRESP, RD, RDATA, RRESP.
- Reset: state goes to IDLE. `aw_held` and `w_held` clear. `awready`/`wready` are 1 (IDLE, nothing held). `arready` is 1 only if no write is presented or held. `bvalid`, `rvalid`, `mem_wen` and `mem_ren` are 0. `bresp`, `rresp`, `rdata`, `mem_addr` and `mem_wdata` are 0.
- IDLE behaviour:
  - `awready = !aw_held` and `wready = !w_held`. The AW and W channels latch independently, in either order or in the same cycle.
  - `arready = !aw_held && !w_held && !awvalid && !wvalid`. A write that is held or presented blocks read acceptance, so writes win.
- IDLE to WR: taken when both halves are held, or when the second half handshakes in this cycle.
- WR (one cycle):
  - Address in range: `mem_addr = (awaddr_q - BASE_ADDR) >> 2`, `mem_wdata = wdata_q`, `mem_wen = wstrb_q`.
  - Address out of range: `mem_wen = 0`.
  - Next state is BRESP.
- BRESP:
  - `bvalid = 1`. `bresp` is 2'b00 (OKAY) when in range, 2'b10 (SLVERR) otherwise.
  - Held until `bready`. On the handshake, clear both held flags and go to IDLE.
- IDLE to RD: taken on the AR handshake; `araddr` is latched.
- RD (one cycle): `mem_ren = 1` and `mem_addr` is driven, but only if in range.
- RDATA (one cycle): `rdata_q` captures `mem_rdata` when in range, else 0.
- RRESP:
  - `rvalid = 1`. `rresp` is OKAY or SLVERR by the same range rule.
  - `rdata` holds stable until `rready`, then go to IDLE.
- Range rule: in range iff `BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS`. Compute this in 33 bits so the upper bound cannot wrap. Address bits [1:0] are ignored.
- `wstrb = 0` in range: the write completes with OKAY and no byte changes.
- No outstanding transactions beyond one; no bursts, no IDs.

## Timing
- Write latency: last of AW/W handshakes at edge N → WR during cycle N+1 → `bvalid` rises after edge N+1 (cycle N+2).
- Read latency: AR handshake at edge N → RD cycle N+1 → RDATA cycle N+2 → `rvalid` in cycle N+3.
- Holding `bready`/`rready` low stalls indefinitely. Responses and data stay constant while stalled, and no new address is accepted.
- `arvalid` arriving in the same cycle as `awvalid` in IDLE: the write is served first and the read is accepted after BRESP completes.
- `rst` asserted mid-transaction (any state): the next edge returns to the reset values, held flags clear, and the in-flight transaction is dropped with no response. `mem_wen` must be 0 in the cycle after reset, even if reset hit in WR.
- Back-to-back: IDLE is the only state that accepts new addresses. The minimum write-to-write spacing is 3 cycles when `bready` is tied high.

## Test plan
- Strobe merge:
  - Write 32'h5678_0000 to 32'h0000_1000 with strobe 4'b1100 → OKAY.
  - Write 32'hABCD_1234 to 32'h0000_1000 with strobe 4'b0011 → OKAY.
  - Read 32'h0000_1000 → `rdata` 32'h5678_1234, OKAY, `rvalid` 3 cycles after the AR handshake.
- Channel ordering:
  - W handshake 2 cycles before AW, then the reverse order, then both in the same cycle. Each case gives exactly one `mem_wen` pulse and one `bvalid`.
- Out-of-range access:
  - Write to 32'h0000_2000 (MEM_WORDS=1024) → SLVERR and `mem_wen` never nonzero.
  - Read from 32'h0000_0FFC → SLVERR, `rdata` 0, `mem_ren` never asserted.
- Priority: `arvalid` and `awvalid`/`wvalid` raised together in IDLE → the B response completes before `arready` rises. The read then returns the newly written data.
- Backpressure:
  - Hold `rready` low 10 cycles → `rvalid`, `rdata` and `rresp` stay constant, and `arready`/`awready` stay 0.
  - Hold `bready` low 10 cycles → `bvalid` and `bresp` stay constant, and `arready`/`awready` stay 0.
- Reset mid-op:
  - Assert `rst` for 1 cycle while in RD → all outputs return to reset values, and a following read of a known word returns the correct data.
  - Assert `rst` for 1 cycle while in BRESP → all outputs return to reset values, and a following read of a known word returns the correct data.
